// File: rtl/uart_bus_bridge.sv
// UART-to-parallel-bus bridge: decodes command/address/data byte frames into
// single bus cycles and returns read data as one response word.
module uart_bus_bridge #(
   parameter int ADDR_BYTES = 4,
   parameter int DATA_BYTES = 4,
   parameter int BYTE_TO    = 250000,
   parameter int BUS_TO     = 255,
   localparam int ADDR_W    = 8 * ADDR_BYTES,
   localparam int DATA_W    = 8 * DATA_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_ready,
   input  logic [7:0]        rx_data,
   input  logic              tx_ready,
   output logic              tx_load,
   output logic [DATA_W-1:0] tx_data,
   output logic              frame_,
   output logic              irdy_,
   input  logic              trdy_,
   output logic [ADDR_W-1:0] adr,
   output logic [3:0]        cbe,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              err_cmd,
   output logic              err_bus,
   output logic              err_byte,
   output logic [2:0]        dbg_state_o
);

   localparam int BT_W = $clog2(BYTE_TO + 1);
   localparam int BU_W = $clog2(BUS_TO + 1);

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] CMD_CLR = 8'h43;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      DATA     = 3'd2,
      BUS_ADDR = 3'd3,
      BUS_WAIT = 3'd4,
      RESP     = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [3:0]          cbe_q, cbe_d;
   logic                is_wr_q, is_wr_d;
   logic [2:0]          byte_cnt_q, byte_cnt_d;
   logic [BT_W-1:0]     byte_to_q, byte_to_d;
   logic [BU_W-1:0]     bus_to_q, bus_to_d;
   logic                err_cmd_q, err_cmd_d;
   logic                err_bus_q, err_bus_d;
   logic                err_byte_q, err_byte_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         adr_q      <= '0;
         wdata_q    <= '0;
         tx_data_q  <= '0;
         cbe_q      <= '0;
         is_wr_q    <= 1'b0;
         byte_cnt_q <= '0;
         byte_to_q  <= '0;
         bus_to_q   <= '0;
         err_cmd_q  <= 1'b0;
         err_bus_q  <= 1'b0;
         err_byte_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         adr_q      <= adr_d;
         wdata_q    <= wdata_d;
         tx_data_q  <= tx_data_d;
         cbe_q      <= cbe_d;
         is_wr_q    <= is_wr_d;
         byte_cnt_q <= byte_cnt_d;
         byte_to_q  <= byte_to_d;
         bus_to_q   <= bus_to_d;
         err_cmd_q  <= err_cmd_d;
         err_bus_q  <= err_bus_d;
         err_byte_q <= err_byte_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      wdata_d    = wdata_q;
      tx_data_d  = tx_data_q;
      cbe_d      = cbe_q;
      is_wr_d    = is_wr_q;
      byte_cnt_d = byte_cnt_q;
      byte_to_d  = byte_to_q;
      bus_to_d   = '0;
      err_cmd_d  = 1'b0;
      err_bus_d  = err_bus_q;
      err_byte_d = err_byte_q;
      case (state_q)
         IDLE: begin
            byte_cnt_d = '0;
            byte_to_d  = '0;
            if (rx_ready) begin
               case (rx_data)
                  CMD_WR: begin
                     is_wr_d = 1'b1;
                     cbe_d   = 4'h7;
                     state_d = ADDR;
                  end
                  CMD_RD: begin
                     is_wr_d = 1'b0;
                     cbe_d   = 4'h6;
                     state_d = ADDR;
                  end
                  CMD_CLR: begin
                     err_bus_d  = 1'b0;
                     err_byte_d = 1'b0;
                  end
                  default: err_cmd_d = 1'b1;
               endcase
            end
         end
         // Address and data collection share the inter-byte idle timeout.
         ADDR, DATA: begin
            if (rx_ready) begin
               byte_to_d = '0;
               if (state_q == ADDR) begin
                  adr_d = (adr_q << 8) | ADDR_W'(rx_data);
                  if (byte_cnt_q == 3'(ADDR_BYTES - 1)) begin
                     byte_cnt_d = '0;
                     state_d    = is_wr_q ? DATA : BUS_ADDR;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 3'd1;
                  end
               end else begin
                  wdata_d = (wdata_q << 8) | DATA_W'(rx_data);
                  if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
                     byte_cnt_d = '0;
                     state_d    = BUS_ADDR;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 3'd1;
                  end
               end
            end else if (byte_to_q == BT_W'(BYTE_TO - 1)) begin
               err_byte_d = 1'b1;
               state_d    = IDLE;
            end else begin
               byte_to_d = byte_to_q + BT_W'(1);
            end
         end
         BUS_ADDR: state_d = BUS_WAIT;
         BUS_WAIT: begin
            if (!trdy_) begin
               if (!is_wr_q) tx_data_d = rdata;
               state_d = is_wr_q ? IDLE : RESP;
            end else if (bus_to_q == BU_W'(BUS_TO - 1)) begin
               err_bus_d = 1'b1;
               if (!is_wr_q) tx_data_d = '1;
               state_d = is_wr_q ? IDLE : RESP;
            end else begin
               bus_to_d = bus_to_q + BU_W'(1);
            end
         end
         RESP: if (tx_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign frame_      = (state_q != BUS_ADDR);
   assign irdy_       = (state_q != BUS_WAIT);
   assign tx_load     = (state_q == RESP) && tx_ready;
   assign tx_data     = tx_data_q;
   assign adr         = adr_q;
   assign cbe         = cbe_q;
   assign wdata       = wdata_q;
   assign busy        = (state_q != IDLE);
   assign err_cmd     = err_cmd_q;
   assign err_bus     = err_bus_q;
   assign err_byte    = err_byte_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 4, address bytes per frame (1..4); ADDR_W = 8*ADDR_BYTES.
REQ-002 SHALL have parameter DATA_BYTES, default 4, data bytes per frame (1..4); DATA_W = 8*DATA_BYTES.
REQ-003 SHALL have parameter BYTE_TO, default 250000, max idle clk cycles between bytes of one frame.
REQ-004 SHALL have parameter BUS_TO, default 255, max clk cycles waiting for trdy_.
REQ-005 SHALL have ports: clk in 1, sole clock; rst in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: rx_ready in 1, one-cycle byte strobe; rx_data in 8, received byte.
REQ-007 SHALL have ports: tx_ready in 1, transmitter idle; tx_load out 1, one-cycle load strobe; tx_data out DATA_W, response word.
REQ-008 SHALL have ports: frame_ out 1, active-low cycle start; irdy_ out 1, active-low initiator ready; trdy_ in 1, active-low target ready.
REQ-009 SHALL have ports: adr out ADDR_W, cycle address; cbe out 4, command code; wdata out DATA_W; rdata in DATA_W.
REQ-010 SHALL have ports: busy out 1, FSM not IDLE; err_cmd out 1, one-cycle pulse; err_bus out 1, sticky; err_byte out 1, sticky.

Function
REQ-011 Frame SHALL be: command byte, then ADDR_BYTES address bytes MSB first, then (write only) DATA_BYTES data bytes MSB first.
REQ-012 Command 0x57 SHALL mean write, cbe=4'h7; 0x52 SHALL mean read, cbe=4'h6.
REQ-013 In IDLE, any other command byte SHALL be discarded, pulse err_cmd for one cycle, and remain in IDLE.
REQ-014 FSM states SHALL be IDLE, ADDR, DATA, BUS_ADDR, BUS_WAIT, RESP.
REQ-015 Transitions: IDLE->ADDR on valid command; ADDR->DATA (write) or ->BUS_ADDR (read) after last address byte; DATA->BUS_ADDR after last data byte.
REQ-016 BUS_ADDR SHALL last exactly one cycle, with frame_=0, irdy_=1, adr and cbe valid, then go to BUS_WAIT.
REQ-017 In BUS_WAIT: frame_=1, irdy_=0, adr/cbe/wdata held stable.
REQ-018 trdy_ sampled 0 in BUS_WAIT SHALL end the cycle; irdy_ returns to 1 the following cycle.
REQ-019 On a read, rdata SHALL be captured in the same cycle trdy_ is sampled 0.
REQ-020 A byte-timeout counter SHALL reset on every rx_ready and count in ADDR/DATA; reaching BYTE_TO SHALL drop the frame, set err_byte, and go to IDLE.
REQ-021 A bus-timeout counter SHALL count in BUS_WAIT; reaching BUS_TO with trdy_ still 1 SHALL end the cycle and set err_bus.
REQ-022 On bus timeout during a read, the response word SHALL be all ones.
REQ-023 Write completion (acked or timed out) SHALL go directly to IDLE; no response is sent.
REQ-024 Read completion SHALL go to RESP; tx_load SHALL pulse one cycle on the first cycle tx_ready=1, with tx_data valid that cycle and held until the next response; then IDLE.
REQ-025 rx_ready in BUS_ADDR, BUS_WAIT or RESP SHALL be ignored (byte dropped, no error).
REQ-026 trdy_ outside BUS_WAIT SHALL be ignored.
REQ-027 Latency SHALL be: last frame byte strobe -> frame_=0 on the next cycle.
REQ-028 err_bus and err_byte SHALL clear only on reset or on receipt of command 0x43 in IDLE; 0x43 SHALL generate no bus cycle and no err_cmd.

Reset
REQ-029 On rst=1 at a clk edge, all outputs SHALL be: FSM=IDLE, frame_=1, irdy_=1, tx_load=0, busy=0, all err*=0, adr=0, cbe=0, wdata=0, tx_data=0.
REQ-030 Reset SHALL win over every concurrent event, including mid-BUS_WAIT: irdy_=1 the cycle after reset, and no tx_load is issued.

Verification (ADDR_BYTES=2, DATA_BYTES=4, BUS_TO=8, BYTE_TO=100)
REQ-031 Write: bytes 57 00 10 DE AD BE EF, trdy_=0 on the 3rd BUS_WAIT cycle -> one-cycle frame_=0 with adr=0x0010, cbe=7, wdata=0xDEADBEEF; irdy_ low 3 cycles; no tx_load.
REQ-032 Read: bytes 52 00 20, rdata=0x12345678 with trdy_=0; tx_ready held 0 for 5 cycles then 1 -> tx_load single pulse with tx_data=0x12345678.
REQ-033 Bus timeout: read 52 00 30, trdy_ held 1 -> irdy_ low exactly 8 cycles, err_bus=1, tx_data=0xFFFFFFFF loaded; then 43 -> err_bus=0.
REQ-034 Byte timeout: 57 00, then 101 idle cycles -> err_byte=1, busy=0, no frame_; a following valid write completes normally.
REQ-035 Bad command: 41 -> err_cmd pulses one cycle; busy stays 0; next 52 00 01 runs normally.
REQ-036 Reset mid-operation: rst=1 during BUS_WAIT of a read -> next cycle irdy_=1, busy=0; no tx_load afterwards.
